fp8_dot_sequencer: RTL

FP8_DOT_SEQUENCER -- requirements
Module: fp8_dot_sequencer

---
 rtl/fp8_dot_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fp8_dot_sequencer.sv
// fp8_dot_sequencer
//   Sequences an FP8 dot product over an external pipelined multiplier and
//   adder. Operand pairs are staged in a 12-entry A/B buffer, then issued one
//   pair at a time. Each issue is spaced ADD_LAT+1 cycles apart, so the next
//   product meets an accumulator that already holds the previous sum. The
//   adder result is captured into acc96 exactly MUL_LAT+ADD_LAT cycles after
//   each issue.
//
//   Optional feature (compile-time macro FP8_SEQ_BUSY_ERR_EN):
//     defined   -> start96 while busy96 sets a sticky err96, which clears on
//                  rst96 or on the next accepted start96
//     undefined -> err96 is tied low; start96 while busy is silently ignored
//
// Ports
//   clk96            clock, rising edge
//   rst96            asynchronous active-high reset (buffer is not cleared)
//   wr_en96          buffer write strobe (ignored while busy or addr > 11)
//   wr_addr96        buffer entry 0..11
//   wr_a96/wr_b96    FP8 operand pair to store
//   start96          one-cycle start request, len96 sampled with it
//   len96            vector length, clamped to 12; 0 finishes immediately
//   op_a96/op_b96    operands to multiplier, 0x00 when op_valid96 is low
//   op_valid96       one-cycle issue strobe
//   sum_in96         adder result (accumulator + product)
//   acc96            accumulator, drives adder a-input
//   busy96           high from the cycle after start through FINISH
//   done96           one-cycle completion pulse
//   result96         final sum, held until overwritten by the next run
//   err96            sticky busy-start error (see macro above)
module fp8_dot_sequencer #(
    parameter int MUL_LAT = 3,
    parameter int ADD_LAT = 3
) (
    input  logic       clk96,
    input  logic       rst96,
    input  logic       wr_en96,
    input  logic [3:0] wr_addr96,
    input  logic [7:0] wr_a96,
    input  logic [7:0] wr_b96,
    input  logic       start96,
    input  logic [3:0] len96,
    output logic [7:0] op_a96,
    output logic [7:0] op_b96,
    output logic       op_valid96,
    input  logic [7:0] sum_in96,
    output logic [7:0] acc96,
    output logic       busy96,
    output logic       done96,
    output logic [7:0] result96,
    output logic       err96
);

    localparam int         CAP_LAT   = MUL_LAT + ADD_LAT;
    localparam logic [3:0] MAX_LEN   = 4'd12;
    localparam logic [7:0] WAIT_LAST = 8'(ADD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          idx_q;
    logic [3:0]          n_q;
    logic [3:0]          cap_cnt_q;
    logic [7:0]          wcnt_q;
    logic [CAP_LAT-1:0]  vld_pipe;
    logic [7:0]          acc_q;
    logic [7:0]          result_q;
    logic [7:0]          mem_a [12];
    logic [7:0]          mem_b [12];
    logic                start_ok;
    logic                capture;
    logic [3:0]          start_len;

    assign busy96     = (state_q != IDLE);
    assign start_ok   = start96 && (state_q == IDLE);
    assign start_len  = clamp_len(len96);
    assign op_valid96 = (state_q == ISSUE);
    assign op_a96     = op_valid96 ? mem_a[idx_q] : 8'h00;
    assign op_b96     = op_valid96 ? mem_b[idx_q] : 8'h00;
    assign done96     = (state_q == FINISH);
    assign acc96      = acc_q;
    assign result96   = result_q;
    // The oldest bit of the issue-tracking shift register marks the cycle in
    // which that pair's sum is valid on sum_in96.
    assign capture    = vld_pipe[CAP_LAT-1];

    // Operand buffer: plain storage, deliberately untouched by reset.
    always_ff @(posedge clk96) begin
        if (wr_en96 && (wr_addr96 <= 4'd11) && !busy96) begin
            mem_a[wr_addr96] <= wr_a96;
            mem_b[wr_addr96] <= wr_b96;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start96) begin
                    state_d = (start_len == 4'd0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Captures of earlier pairs can land during the final wait,
                // so completion is keyed on the capture count, not on issues.
                if (capture && (cap_cnt_q == n_q - 4'd1)) begin
                    state_d = FINISH;
                end else if ((idx_q != n_q) && (wcnt_q == WAIT_LAST)) begin
                    state_d = ISSUE;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk96 or posedge rst96) begin
        if (rst96) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            n_q       <= '0;
            cap_cnt_q <= '0;
            wcnt_q    <= '0;
            vld_pipe  <= '0;
            acc_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q  <= state_d;
            vld_pipe <= (vld_pipe << 1) | {{(CAP_LAT-1){1'b0}}, op_valid96};
            if (start_ok) begin
                idx_q     <= '0;
                n_q       <= start_len;
                cap_cnt_q <= '0;
                wcnt_q    <= '0;
                acc_q     <= 8'h00;
            end else begin
                if (state_q == ISSUE) begin
                    idx_q  <= idx_q + 4'd1;
                    wcnt_q <= '0;
                end else if (state_q == WAIT) begin
                    wcnt_q <= wcnt_q + 8'd1;
                end
                if (capture) begin
                    acc_q     <= sum_in96;
                    cap_cnt_q <= cap_cnt_q + 4'd1;
                end
            end
            // On entry to FINISH the final sum is the value being captured
            // into acc this same edge; a zero-length run yields 0x00.
            if ((state_d == FINISH) && (state_q != FINISH)) begin
                result_q <= (state_q == WAIT) ? sum_in96 : 8'h00;
            end
        end
    end

`ifdef FP8_SEQ_BUSY_ERR_EN
    logic err_q;

    always_ff @(posedge clk96 or posedge rst96) begin
        if (rst96) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if (start96 && busy96) begin
            err_q <= 1'b1;
        end
    end

    assign err96 = err_q;
`else
    assign err96 = 1'b0;
`endif

endmodule
